// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two CPU masters, the arbiter and the single-port SRAM macro.
// slave = arbiter view, master = CPU view, mem = SRAM macro view.
interface sram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [3:0]        m0_web;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [3:0]        m1_web;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] sram_A;
    logic [DATA_W-1:0] sram_DI;
    logic [DATA_W-1:0] sram_DO;
    logic [3:0]        sram_WEB;
    logic              sram_CS;
    logic              sram_OE;

    modport slave (
        input  m0_req, m0_addr, m0_web, m0_wdata,
        input  m1_req, m1_addr, m1_web, m1_wdata,
        input  sram_DO,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output sram_A, sram_DI, sram_WEB, sram_CS, sram_OE
    );

    modport master (
        output m0_req, m0_addr, m0_web, m0_wdata,
        output m1_req, m1_addr, m1_web, m1_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport mem (
        input  sram_A, sram_DI, sram_WEB, sram_CS, sram_OE,
        output sram_DO
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between fetch (m0) and load/store (m1) with a registered response.
// Define ARB_RR_EN for round-robin arbitration; default is m1 priority with an m0 starvation guard.
module sram_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_arbiter_if.slave  bus
);
    logic m0_win;
    logic m1_win;
    logic both_req;

    assign both_req = bus.m0_req && bus.m1_req;

`ifdef ARB_RR_EN
    // 0 = m0 was granted most recently, so m1 wins the first contention
    logic last_gnt;

    always_comb begin
        m0_win = 1'b0;
        m1_win = 1'b0;
        if (rst_n) begin
            if (both_req) begin
                m0_win = last_gnt;
                m1_win = !last_gnt;
            end else begin
                m0_win = bus.m0_req;
                m1_win = bus.m1_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b0;
        end else if (m1_win) begin
            last_gnt <= 1'b1;
        end else if (m0_win) begin
            last_gnt <= 1'b0;
        end
    end
`else
    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        m0_win = 1'b0;
        m1_win = 1'b0;
        if (rst_n) begin
            if (both_req) begin
                m0_win = starved;
                m1_win = !starved;
            end else begin
                m0_win = bus.m0_req;
                m1_win = bus.m1_req;
            end
        end
    end

    // Counts consecutive cycles m0 waited behind m1; saturates so m0 keeps its forced win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (m0_win || !bus.m0_req) begin
            starve_cnt <= 4'd0;
        end else if (m1_win && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    assign bus.m0_gnt = m0_win;
    assign bus.m1_gnt = m1_win;

    always_comb begin
        bus.sram_CS  = 1'b0;
        bus.sram_OE  = 1'b0;
        bus.sram_WEB = 4'hF;
        bus.sram_A   = '0;
        bus.sram_DI  = '0;
        if (m1_win) begin
            bus.sram_CS  = 1'b1;
            bus.sram_OE  = 1'b1;
            bus.sram_WEB = bus.m1_web;
            bus.sram_A   = bus.m1_addr;
            bus.sram_DI  = bus.m1_wdata;
        end else if (m0_win) begin
            bus.sram_CS  = 1'b1;
            bus.sram_OE  = 1'b1;
            bus.sram_WEB = bus.m0_web;
            bus.sram_A   = bus.m0_addr;
            bus.sram_DI  = bus.m0_wdata;
        end
    end

    // Response stage: the macro output already carries the merged word on writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rdata  <= '0;
        end else begin
            bus.m0_rvalid <= m0_win;
            bus.m1_rvalid <= m1_win;
            if (m0_win) begin
                bus.m0_rdata <= bus.sram_DO;
            end
            if (m1_win) begin
                bus.m1_rdata <= bus.sram_DO;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed table-driven bench for sram_arbiter with a behavioural byte-lane SRAM model.
module tb_sram_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

`ifdef ARB_RR_EN
    localparam logic [9:0] CONT_PAT = 10'b1010101010;
`else
    localparam logic [9:0] CONT_PAT = 10'b1111011110;
`endif

    typedef struct {
        logic        m0_req;
        logic [13:0] m0_addr;
        logic [3:0]  m0_web;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic [13:0] m1_addr;
        logic [3:0]  m1_web;
        logic [31:0] m1_wdata;
        logic        e_m0_gnt;
        logic        e_m1_gnt;
        logic        e_m0_rv;
        logic        e_m1_rv;
        logic [31:0] e_m0_rd;
        logic [31:0] e_m1_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    bit          written [256];

    function automatic logic [31:0] mem_rd(input logic [7:0] a);
        return written[a] ? mem[a] : (32'h1000_0000 + 32'(a));
    endfunction

    always_comb begin
        logic [31:0] old;
        old = mem_rd(bus.sram_A[7:0]);
        bus.sram_DO = old;
        for (int i = 0; i < 4; i++) begin
            if (!bus.sram_WEB[i]) bus.sram_DO[i*8 +: 8] = bus.sram_DI[i*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (bus.sram_CS && bus.sram_WEB != 4'hF) begin
            mem[bus.sram_A[7:0]]     <= bus.sram_DO;
            written[bus.sram_A[7:0]] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r0, input logic [13:0] a0, input logic [3:0] w0,
                                input logic [31:0] d0, input logic r1, input logic [13:0] a1,
                                input logic [3:0] w1, input logic [31:0] d1,
                                input logic g0, input logic g1, input logic v0, input logic v1,
                                input logic [31:0] rd0, input logic [31:0] rd1);
        vec_t v;
        v.m0_req = r0; v.m0_addr = a0; v.m0_web = w0; v.m0_wdata = d0;
        v.m1_req = r1; v.m1_addr = a1; v.m1_web = w1; v.m1_wdata = d1;
        v.e_m0_gnt = g0; v.e_m1_gnt = g1; v.e_m0_rv = v0; v.e_m1_rv = v1;
        v.e_m0_rd = rd0; v.e_m1_rd = rd1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.m0_req = v.m0_req; bus.m0_addr = v.m0_addr; bus.m0_web = v.m0_web; bus.m0_wdata = v.m0_wdata;
        bus.m1_req = v.m1_req; bus.m1_addr = v.m1_addr; bus.m1_web = v.m1_web; bus.m1_wdata = v.m1_wdata;
    endtask

    vec_t vt[$];
    vec_t idle;

    initial begin
        logic        m1w;
        logic        prev_m1;
        logic [3:0]  exp_web;
        idle = mk(0, 0, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0);

        // Test table, one record per cycle; rvalid/rdata expectations answer the previous row
        vt.push_back(mk(0, 14'h0, 4'hF, 0, 1, 14'h10, 4'h0, 32'hDEADBEEF, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 14'h10, 4'hF, 0, 0, 0, 4'hF, 0, 1, 0, 0, 1, 0, 32'hDEADBEEF));
        vt.push_back(mk(0, 14'h0, 4'hF, 0, 1, 14'h10, 4'b1110, 32'h000000AA, 0, 1, 1, 0, 32'hDEADBEEF, 0));
        vt.push_back(mk(1, 14'h10, 4'hF, 0, 0, 0, 4'hF, 0, 1, 0, 0, 1, 0, 32'hDEADBEAA));
        vt.push_back(mk(1, 14'h0, 4'hF, 0, 0, 0, 4'hF, 0, 1, 0, 1, 0, 32'hDEADBEAA, 0));
        vt.push_back(mk(1, 14'h1, 4'hF, 0, 0, 0, 4'hF, 0, 1, 0, 1, 0, 32'h10000000, 0));
        vt.push_back(mk(1, 14'h2, 4'hF, 0, 0, 0, 4'hF, 0, 1, 0, 1, 0, 32'h10000001, 0));
        vt.push_back(mk(1, 14'h3, 4'hF, 0, 0, 0, 4'hF, 0, 1, 0, 1, 0, 32'h10000002, 0));
        vt.push_back(mk(0, 14'h0, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0, 32'h10000003, 0));
        prev_m1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            m1w = CONT_PAT[9-i];
            vt.push_back(mk(1, 14'h20, 4'hF, 0, 1, 14'h21, 4'hF, 0, !m1w, m1w,
                            (i > 0) && !prev_m1, (i > 0) && prev_m1, 32'h10000020, 32'h10000021));
            prev_m1 = m1w;
        end
        vt.push_back(mk(0, 0, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0, !prev_m1, prev_m1, 32'h10000020, 32'h10000021));

        // Reset state with both masters requesting: no grant, idle macro, cleared responses
        bus.m0_req = 1; bus.m0_addr = 14'h5; bus.m0_web = 4'h0; bus.m0_wdata = 32'h1234;
        bus.m1_req = 1; bus.m1_addr = 14'h6; bus.m1_web = 4'h0; bus.m1_wdata = 32'h5678;
        repeat (2) @(negedge clk);
        chk("rst_m0_gnt", 32'(bus.m0_gnt), 0);
        chk("rst_m1_gnt", 32'(bus.m1_gnt), 0);
        chk("rst_cs", 32'(bus.sram_CS), 0);
        chk("rst_oe", 32'(bus.sram_OE), 0);
        chk("rst_web", 32'(bus.sram_WEB), 32'hF);
        chk("rst_a", 32'(bus.sram_A), 0);
        chk("rst_di", bus.sram_DI, 0);
        chk("rst_m0_rv", 32'(bus.m0_rvalid), 0);
        chk("rst_m1_rv", 32'(bus.m1_rvalid), 0);
        chk("rst_m0_rd", bus.m0_rdata, 0);
        chk("rst_m1_rd", bus.m1_rdata, 0);
        drive(idle);
        @(posedge clk); #1 rst_n = 1'b1;

        foreach (vt[k]) begin
            @(posedge clk); #1;
            drive(vt[k]);
            @(negedge clk);
            chk($sformatf("v%0d_m0_gnt", k), 32'(bus.m0_gnt), 32'(vt[k].e_m0_gnt));
            chk($sformatf("v%0d_m1_gnt", k), 32'(bus.m1_gnt), 32'(vt[k].e_m1_gnt));
            chk($sformatf("v%0d_cs", k), 32'(bus.sram_CS), 32'(vt[k].e_m0_gnt | vt[k].e_m1_gnt));
            exp_web = vt[k].e_m1_gnt ? vt[k].m1_web : (vt[k].e_m0_gnt ? vt[k].m0_web : 4'hF);
            chk($sformatf("v%0d_web", k), 32'(bus.sram_WEB), 32'(exp_web));
            chk($sformatf("v%0d_m0_rv", k), 32'(bus.m0_rvalid), 32'(vt[k].e_m0_rv));
            chk($sformatf("v%0d_m1_rv", k), 32'(bus.m1_rvalid), 32'(vt[k].e_m1_rv));
            if (vt[k].e_m0_rv) chk($sformatf("v%0d_m0_rd", k), bus.m0_rdata, vt[k].e_m0_rd);
            if (vt[k].e_m1_rv) chk($sformatf("v%0d_m1_rd", k), bus.m1_rdata, vt[k].e_m1_rd);
        end

        // Reset mid-access: granted m0 read must never deliver its response
        @(posedge clk); #1;
        drive(idle);
        bus.m0_req = 1; bus.m0_addr = 14'h10;
        @(negedge clk);
        chk("mid_gnt_before", 32'(bus.m0_gnt), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_gnt_rst", 32'(bus.m0_gnt), 0);
        chk("mid_cs_rst", 32'(bus.sram_CS), 0);
        chk("mid_oe_rst", 32'(bus.sram_OE), 0);
        chk("mid_web_rst", 32'(bus.sram_WEB), 32'hF);
        chk("mid_a_rst", 32'(bus.sram_A), 0);
        chk("mid_m0_rd_rst", bus.m0_rdata, 0);
        chk("mid_m1_rd_rst", bus.m1_rdata, 0);
        @(posedge clk); #1;
        chk("mid_rv_in_rst", 32'(bus.m0_rvalid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_first_gnt", 32'(bus.m0_gnt), 1);
        chk("mid_rv_dropped", 32'(bus.m0_rvalid), 0);
        @(posedge clk); #1;
        drive(idle);
        @(negedge clk);
        chk("post_rv", 32'(bus.m0_rvalid), 1);
        chk("post_rd", bus.m0_rdata, 32'hDEADBEAA);
        chk("post_m1_rv", 32'(bus.m1_rvalid), 0);
        @(negedge clk);
        chk("post_rv_pulse", 32'(bus.m0_rvalid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
